s0_rs_enc: RTL and testbench
============================

# s0_rs_enc

Systematic Reed-Solomon encoder over GF(2^8), the transmit-side counterpart of the s1–s3 decoder chain. It accepts K message bytes on a valid/ready stream and passes them through unchanged. It then appends the 4 parity bytes of the generator g(x) = (x+α^0)(x+α^1)(x+α^2)(x+α^3), with α = 0x02 and primitive polynomial 0x11D. A clean codeword therefore gives rs_syn0..rs_syn3 = 0 at the decoder.

## Interface
- K, default 251: message bytes per codeword; legal range 1..251 (shortened codes allowed); codeword length N = K+4.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  encoder accepts in_data this cycle.
- in_data  input  8  message byte, first byte = highest-degree coefficient.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  8  codeword byte (message, then parity).
- out_last  output  1  marks the final (4th parity) byte of the codeword.
- out_par  output  1  out_data is a parity byte.

## Operation
- Generator coefficients are fixed: g(x) = x^4 + 0x0F·x^3 + 0x36·x^2 + 0x78·x + 0x40.
- Parity register r0..r3 (8 bits each) resets to 0. The state machine has two states: MSG (reset state) and PAR. It uses counter msg_cnt of 0..K-1 and counter par_cnt of 0..3.
- An output slot is free when !out_valid || out_ready.
- In MSG:
  - in_ready = free.
  - On accept (in_valid && in_ready):
    - fb = in_data ^ r3.
    - r3 ← r2 ^ fb·0x0F, r2 ← r1 ^ fb·0x36, r1 ← r0 ^ fb·0x78, r0 ← fb·0x40.
    - out_data ← in_data, out_par ← 0, out_last ← 0, out_valid ← 1.
    - msg_cnt increments.
  - On accepting byte K-1: msg_cnt ← 0 and the state goes to PAR.
- In PAR:
  - in_ready = 0.
  - When free: out_data ← r3, then shift r3←r2, r2←r1, r1←r0, r0←0; set out_par ← 1, out_valid ← 1, and out_last ← (par_cnt==3).
  - After the 4th parity load: par_cnt ← 0 and the state goes to MSG. r0..r3 are now all zero, so no explicit clear is needed.
- If free and nothing is loaded this cycle, out_valid ← 0.
- All GF products are by constants; no GF division or inversion is used.

## Timing
- Reset values: out_valid 0, out_data 0x00, out_last 0, out_par 0, and state, counters and r0..r3 all zero. in_ready is 0 while rst is high and 1 in the first cycle after release.
- Latency: each accepted byte appears on out_data the next cycle. The first parity byte appears the cycle after the output slot holding message byte K-1 frees.
- Throughput with out_ready held high:
  - One byte per cycle.
  - A codeword takes K+4 cycles, with in_ready low for exactly 4 cycles per codeword.
  - Back-to-back codewords have no bubble: message byte 0 of the next codeword is accepted in the cycle after the last parity byte is loaded.
- Stall (out_valid && !out_ready): out_data, out_last, out_par, r0..r3 and the counters all hold, and in_ready = 0.
- in_valid low in MSG: nothing changes except that out_valid may drop when the slot frees. Gaps mid-message are legal.
- Reset mid-codeword: the partial codeword is discarded immediately and the next accepted byte starts a new codeword.
- K=1: the state goes to PAR after the single accepted byte.

## Structure
- The shared package holds:
  - GF primitive polynomial 0x11D.
  - Generator constants G3=0x0F, G2=0x36, G1=0x78, G0=0x40.
  - Number of parity bytes NPAR=4.
  - State encoding ST_MSG/ST_PAR.
- The four feedback products use four instances of the existing gf2m8_multi, with the y input tied to the constant. Synthesis reduces each to XOR networks.
- One file, no further sub-modules.

## Test plan
- K=251, all-zero message, out_ready=1 → 251 bytes of 0x00, then parity 00 00 00 00; out_last high only on the 255th output byte.
- K=251, message bytes 0..249 = 0x00, byte 250 = 0x01 → parity emitted in order 0F 36 78 40.
- out_ready driven by a random 50% pattern, random message → output stream byte-identical to the unstalled run; values hold during stalls; in_ready never high while the output is stalled.
- Three back-to-back codewords with in_valid held high → 3·(K+4) outputs in 3·(K+4) cycles; in_ready low for exactly 4 cycles after each message.
- Assert rst after 100 accepted bytes, then encode the single-0x01 vector → 0F 36 78 40 again, with no residue from the aborted codeword.
- K=188, random messages, 200 codewords → each codeword fed to the decoder syndrome stage gives rs_syn0..3 = 0; a single injected byte error gives nonzero syndromes and is corrected by the decoder chain.

Source files
------------

// File: rtl/s0_rs_enc_pkg.sv
// Shared constants for the RS(N,K) encoder over GF(2^8): field polynomial,
// generator coefficients and FSM state encoding.
package s0_rs_enc_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam logic [7:0] GF_RED  = GF_POLY[7:0];

  // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^0..alpha^3
  localparam logic [7:0] G3 = 8'h0F;
  localparam logic [7:0] G2 = 8'h36;
  localparam logic [7:0] G1 = 8'h78;
  localparam logic [7:0] G0 = 8'h40;

  localparam int unsigned NPAR = 4;

  typedef enum logic {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } state_t;

endpackage

// File: rtl/gf2m8_multi.sv
// GF(2^8) multiplier (shift-and-add with modular reduction). With one operand
// tied to a constant it collapses to a pure XOR network.
module gf2m8_multi
  import s0_rs_enc_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] z
);

  logic [7:0] acc;
  logic [7:0] xs;

  always_comb begin
    acc = 8'h00;
    xs  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ xs;
      xs = {xs[6:0], 1'b0} ^ (xs[7] ? GF_RED : 8'h00);
    end
    z = acc;
  end

endmodule

// File: rtl/s0_rs_enc.sv
// Systematic RS encoder: passes K message bytes through on a valid/ready
// stream, then appends the 4 parity bytes of g(x).
module s0_rs_enc
  import s0_rs_enc_pkg::*;
#(
  parameter int unsigned K = 251
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_par
);

  localparam int unsigned CW = 8;

  state_t        state_q, state_d;
  logic [CW-1:0] msg_cnt_q, msg_cnt_d;
  logic [1:0]    par_cnt_q, par_cnt_d;
  logic [7:0]    r0_q, r1_q, r2_q, r3_q;
  logic [7:0]    r0_d, r1_d, r2_d, r3_d;
  logic          out_valid_d, out_last_d, out_par_d;
  logic [7:0]    out_data_d;

  logic       free;
  logic       accept;
  logic [7:0] fb;
  logic [7:0] p3, p2, p1, p0;

  assign free     = !out_valid || out_ready;
  assign in_ready = !rst && (state_q == ST_MSG) && free;
  assign accept   = in_valid && in_ready;
  assign fb       = in_data ^ r3_q;

  // Constant-coefficient feedback products
  gf2m8_multi u_mul3 (.x(fb), .y(G3), .z(p3));
  gf2m8_multi u_mul2 (.x(fb), .y(G2), .z(p2));
  gf2m8_multi u_mul1 (.x(fb), .y(G1), .z(p1));
  gf2m8_multi u_mul0 (.x(fb), .y(G0), .z(p0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_MSG;
      msg_cnt_q <= '0;
      par_cnt_q <= '0;
      r0_q      <= 8'h00;
      r1_q      <= 8'h00;
      r2_q      <= 8'h00;
      r3_q      <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      out_par   <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_cnt_q <= msg_cnt_d;
      par_cnt_q <= par_cnt_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      r3_q      <= r3_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      out_par   <= out_par_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    msg_cnt_d   = msg_cnt_q;
    par_cnt_d   = par_cnt_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    out_par_d   = out_par;

    unique case (state_q)
      ST_MSG: begin
        if (accept) begin
          r3_d        = r2_q ^ p3;
          r2_d        = r1_q ^ p2;
          r1_d        = r0_q ^ p1;
          r0_d        = p0;
          out_data_d  = in_data;
          out_par_d   = 1'b0;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          if (msg_cnt_q == CW'(K - 1)) begin
            msg_cnt_d = '0;
            state_d   = ST_PAR;
          end else begin
            msg_cnt_d = msg_cnt_q + CW'(1);
          end
        end else if (free) begin
          out_valid_d = 1'b0;
        end
      end
      ST_PAR: begin
        // Parity drains from the top of the register; zeros shift in behind
        if (free) begin
          out_data_d  = r3_q;
          r3_d        = r2_q;
          r2_d        = r1_q;
          r1_d        = r0_q;
          r0_d        = 8'h00;
          out_par_d   = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (par_cnt_q == 2'(NPAR - 1));
          if (par_cnt_q == 2'(NPAR - 1)) begin
            par_cnt_d = '0;
            state_d   = ST_MSG;
          end else begin
            par_cnt_d = par_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_MSG;
    endcase
  end

endmodule

// File: tb/tb_s0_rs_enc.sv
// Self-checking bench for s0_rs_enc: polynomial-division reference model,
// random stalls/gaps, back-to-back throughput, mid-codeword reset and K=1.
module tb_s0_rs_enc;

  localparam int unsigned K  = 251;
  localparam int unsigned KS = 1;
  localparam int unsigned N  = K + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       out_ready;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_par;
  logic [7:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_par;
  logic [7:0] b_in_data, b_out_data;

  always #5 clk = ~clk;

  s0_rs_enc #(.K(K)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .out_par(a_out_par)
  );

  s0_rs_enc #(.K(KS)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_par(b_out_par)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // entries are {data[7:0], par, last}
  logic [7:0] a_in_q[$], b_in_q[$];
  logic [9:0] a_out_q[$], b_out_q[$], a_exp_q[$], b_exp_q[$];
  logic [7:0] msg [0:K-1];

  logic       a_hold_chk = 1'b0;
  logic [9:0] a_hold;
  int         a_acc_cnt = 0;
  int         cyc = 0;
  bit         meas = 1'b0;
  int         first_acc, last_hs, ready_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
    return p[7:0];
  endfunction

  // Reference: expand g(x) from its roots, then long-divide m(x)*x^4 by g(x)
  task automatic encode_push(input int which, input int k);
    logic [7:0] g [0:4];
    logic [7:0] rem [0:K+3];
    logic [7:0] c, root;
    g[0] = 8'h01;
    for (int d = 1; d <= 4; d++) g[d] = 8'h00;
    root = 8'h01;
    for (int r = 0; r < 4; r++) begin
      for (int d = 4; d >= 1; d--) g[d] = g[d-1] ^ gf_mul(g[d], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    for (int i = 0; i < k; i++) rem[i] = msg[i];
    for (int i = 0; i < 4; i++) rem[k+i] = 8'h00;
    for (int i = 0; i < k; i++) begin
      c = rem[i];
      for (int j = 1; j <= 4; j++) rem[i+j] = rem[i+j] ^ gf_mul(c, g[4-j]);
    end
    for (int i = 0; i < k; i++) begin
      if (which == 0) begin a_in_q.push_back(msg[i]); a_exp_q.push_back({msg[i], 2'b00}); end
      else            begin b_in_q.push_back(msg[i]); b_exp_q.push_back({msg[i], 2'b00}); end
    end
    for (int i = 0; i < 4; i++) begin
      if (which == 0) a_exp_q.push_back({rem[k+i], 1'b1, 1'(i == 3)});
      else            b_exp_q.push_back({rem[k+i], 1'b1, 1'(i == 3)});
    end
  endtask

  task automatic step(input bit rnd, input bit gaps);
    bit a_acc, a_hs, b_acc, b_hs;
    @(negedge clk);
    out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    a_in_valid = (a_in_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    a_in_data  = (a_in_q.size() > 0) ? a_in_q[0] : 8'($urandom);
    b_in_valid = (b_in_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    b_in_data  = (b_in_q.size() > 0) ? b_in_q[0] : 8'($urandom);
    #1;
    if (a_hold_chk) begin
      chk("hold_data", 32'(a_out_data), 32'(a_hold[9:2]));
      chk("hold_par_last", 32'({a_out_par, a_out_last}), 32'(a_hold[1:0]));
      chk("hold_valid", 32'(a_out_valid), 32'd1);
    end
    a_hold_chk = a_out_valid && !out_ready;
    a_hold     = {a_out_data, a_out_par, a_out_last};
    if (a_out_valid && !out_ready) chk("stall_in_ready", 32'(a_in_ready), 32'd0);
    a_acc = a_in_valid && a_in_ready;
    a_hs  = a_out_valid && out_ready;
    b_acc = b_in_valid && b_in_ready;
    b_hs  = b_out_valid && out_ready;
    if (a_acc) begin void'(a_in_q.pop_front()); a_acc_cnt++; end
    if (b_acc) void'(b_in_q.pop_front());
    if (a_hs) a_out_q.push_back({a_out_data, a_out_par, a_out_last});
    if (b_hs) b_out_q.push_back({b_out_data, b_out_par, b_out_last});
    if (meas) begin
      if (a_acc && first_acc < 0) first_acc = cyc;
      if (first_acc >= 0 && !a_in_ready) ready_low++;
      if (a_hs) last_hs = cyc;
    end
    cyc++;
  endtask

  task automatic drain(input bit rnd, input bit gaps, input int budget);
    int n;
    n = 0;
    while (!(a_out_q.size() >= a_exp_q.size() && b_out_q.size() >= b_exp_q.size())
           && n < budget) begin
      step(rnd, gaps);
      n++;
    end
    chk("drain_count_a", 32'(a_out_q.size()), 32'(a_exp_q.size()));
    chk("drain_count_b", 32'(b_out_q.size()), 32'(b_exp_q.size()));
  endtask

  // Stream compare plus per-codeword syndrome evaluation at alpha^0..alpha^3
  task automatic compare(input string tag, input logic [9:0] got[$], input logic [9:0] exp[$]);
    logic [7:0] s [0:3];
    for (int j = 0; j < 4; j++) s[j] = 8'h00;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk(tag, 32'(got[i]), 32'(exp[i]));
      for (int j = 0; j < 4; j++) s[j] = gf_mul(s[j], 8'(1 << j)) ^ got[i][9:2];
      if (got[i][0]) begin
        for (int j = 0; j < 4; j++) begin
          chk({tag, "_syndrome"}, 32'(s[j]), 32'd0);
          s[j] = 8'h00;
        end
      end
    end
  endtask

  task automatic clear_queues();
    a_in_q.delete(); b_in_q.delete();
    a_out_q.delete(); b_out_q.delete();
    a_exp_q.delete(); b_exp_q.delete();
    a_hold_chk = 1'b0;
  endtask

  task automatic check_single_one_parity(input string tag);
    int base;
    logic [7:0] want [0:3];
    want[0] = 8'h0F; want[1] = 8'h36; want[2] = 8'h78; want[3] = 8'h40;
    base = a_out_q.size() - 4;
    if (base < 0) base = 0;
    for (int i = 0; i < 4; i++)
      if (base + i < a_out_q.size())
        chk(tag, 32'(a_out_q[base+i]), 32'({want[i], 1'b1, 1'(i == 3)}));
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00;
    b_in_valid = 1'b0; b_in_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_last_par", 32'({a_out_last, a_out_par}), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_in_ready_k1", 32'(b_in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // All-zero message
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    encode_push(0, K);
    drain(1'b0, 1'b0, 2000);
    if (a_out_q.size() == N) chk("zero_last_pos", 32'(a_out_q[N-1][0]), 32'd1);
    compare("zero_msg", a_out_q, a_exp_q);
    clear_queues();

    // Single 0x01 in the lowest-degree message position
    msg[K-1] = 8'h01;
    encode_push(0, K);
    drain(1'b0, 1'b0, 2000);
    check_single_one_parity("unit_parity");
    compare("unit_msg", a_out_q, a_exp_q);
    clear_queues();

    // Random data, random backpressure and input gaps; K=1 instance alongside
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
      encode_push(0, K);
    end
    for (int c = 0; c < 6; c++) begin
      msg[0] = 8'($urandom);
      encode_push(1, KS);
    end
    drain(1'b1, 1'b1, 20000);
    compare("rand_stall", a_out_q, a_exp_q);
    compare("k1_stream", b_out_q, b_exp_q);
    clear_queues();

    // Back-to-back codewords at full rate
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
      encode_push(0, K);
    end
    meas = 1'b1; first_acc = -1; last_hs = -1; ready_low = 0;
    drain(1'b0, 1'b0, 4000);
    meas = 1'b0;
    chk("b2b_span", 32'(last_hs - first_acc), 32'(3 * N));
    chk("b2b_ready_low", 32'(ready_low), 32'd12);
    compare("b2b_stream", a_out_q, a_exp_q);
    clear_queues();

    // Reset after 100 accepted bytes, then the unit vector again
    for (int i = 0; i < K; i++) a_in_q.push_back(8'($urandom));
    a_acc_cnt = 0;
    for (int n = 0; n < 1000 && a_acc_cnt < 100; n++) step(1'b1, 1'b0);
    chk("abort_accepted", 32'(a_acc_cnt), 32'd100);
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_queues();
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    msg[K-1] = 8'h01;
    encode_push(0, K);
    drain(1'b0, 1'b0, 2000);
    check_single_one_parity("post_abort_parity");
    compare("post_abort", a_out_q, a_exp_q);
    clear_queues();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
